// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
//   tx_state_t      : serializer states
//   UART_START_BIT  : line level of the start bit
//   UART_STOP_BIT   : line level of the stop bit (and idle)
//   UART_DATA_BITS  : data bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic        UART_START_BIT = 1'b0;
  localparam logic        UART_STOP_BIT  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with wrap-around pointers and no fall-through.
// A word written at edge E is first presented on dout during cycle E+1.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty) and head-of-queue data
//   full, empty: occupancy flags decoded from the registered count
//   count      : occupied entries, 0..DEPTH
module uart_byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte intake into a FIFO, then
// 8N1 serialization, LSB first, on RsTx. Defining UART_TX_PARITY_EN inserts
// an even-parity bit after the data bits (8E1).
//   clk, rst_n : clock, async active-low reset
//   TxData     : byte to send, accepted when TxValid && TxReady
//   TxValid    : TxData valid this cycle
//   TxReady    : FIFO not full
//   RsTx       : serial line, idles high
//   TxBusy     : serializer active or FIFO non-empty
//   FifoCount  : occupied FIFO entries
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    TxData,
  input  logic                          TxValid,
  output logic                          TxReady,
  output logic                          RsTx,
  output logic                          TxBusy,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       rs_tx_q, rs_tx_d;
  logic       busy_q, busy_d;
  logic       pop_c;
  logic       bit_done_c;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  uart_byte_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (TxValid),
    .pop   (pop_c),
    .din   (TxData),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (FifoCount)
  );

  assign TxReady    = !fifo_full;
  assign RsTx       = rs_tx_q;
  assign TxBusy     = busy_q;
  assign bit_done_c = (cnt_q == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      rs_tx_q <= UART_STOP_BIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      rs_tx_q <= rs_tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, bit timing and line level. The line register follows the
  // state by one clock, so a byte accepted at E0 starts its frame at E0+2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop_c   = 1'b0;
    rs_tx_d = UART_STOP_BIT;
    busy_d  = (state_q != IDLE) || !fifo_empty;

    if (state_q != IDLE) cnt_d = bit_done_c ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shreg_d = fifo_dout;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        rs_tx_d = UART_START_BIT;
        if (bit_done_c) state_d = DATA;
      end
      DATA: begin
        rs_tx_d = shreg_q[idx_q];
        if (bit_done_c) begin
          idx_d = idx_q + 3'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        rs_tx_d = ^shreg_q;
        if (bit_done_c) state_d = STOP;
      end
`endif
      STOP: begin
        rs_tx_d = UART_STOP_BIT;
        if (bit_done_c) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
